// File: rtl/wb_pipe_to_classic_bridge.sv
// Pipelined-to-classic Wishbone bridge: buffers requests, issues them one at a time, rejects out-of-range addresses.
// Optional slave acknowledge timeout enabled by defining WB_BRIDGE_TIMEOUT_EN.
module wb_pipe_to_classic_bridge #(
    parameter int unsigned ADR_IN_W       = 28,
    parameter int unsigned ADR_OUT_W      = 26,
    parameter int unsigned DW             = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADR_IN_W-1:0]               s_adr,
    input  logic [DW-1:0]                     s_dat_w,
    input  logic [DW/8-1:0]                   s_sel,
    input  logic                              s_we,
    input  logic                              s_cyc,
    input  logic                              s_stb,
    output logic                              s_stall,
    output logic                              s_ack,
    output logic                              s_err,
    output logic [DW-1:0]                     s_dat_r,
    output logic [ADR_OUT_W-1:0]              m_adr,
    output logic [DW-1:0]                     m_dat_w,
    output logic [DW/8-1:0]                   m_sel,
    output logic                              m_we,
    output logic                              m_cyc,
    output logic                              m_stb,
    input  logic                              m_ack,
    input  logic                              m_err,
    input  logic [DW-1:0]                     m_dat_r,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    generate
        if (ADR_OUT_W > ADR_IN_W || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
            $error("wb_pipe_to_classic_bridge: illegal parameter combination");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADR_OUT_W-1:0]   r_fifo_adr [FIFO_DEPTH];
    logic [DW-1:0]          r_fifo_dat [FIFO_DEPTH];
    logic [SW-1:0]          r_fifo_sel [FIFO_DEPTH];
    logic                   r_fifo_we  [FIFO_DEPTH];
    logic                   r_fifo_oor [FIFO_DEPTH];
    logic [PW-1:0]          r_rd;
    logic [PW-1:0]          r_wr;
    logic [CW-1:0]          r_count;
    logic                   r_drain;

    logic                   r_s_ack;
    logic                   r_s_err;
    logic [DW-1:0]          r_s_dat_r;
    logic                   r_m_cyc;
    logic [ADR_OUT_W-1:0]   r_m_adr;
    logic [DW-1:0]          r_m_dat_w;
    logic [SW-1:0]          r_m_sel;
    logic                   r_m_we;

    logic                   w_in_oor;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_stall;
    logic                   w_push;
    logic                   w_abort;
    logic                   w_hd_valid;
    logic [ADR_OUT_W-1:0]   w_hd_adr;
    logic [DW-1:0]          w_hd_dat;
    logic [SW-1:0]          w_hd_sel;
    logic                   w_hd_we;
    logic                   w_hd_oor;
    logic                   w_timeout;
    logic                   w_resp;

    logic                   w_pop;
    logic                   w_issue;
    logic                   w_cyc_end;
    logic                   w_ack_nxt;
    logic                   w_err_nxt;
    logic                   w_load_dat;
    logic                   w_flush;
    logic                   w_keep;
    logic                   w_drain_nxt;

    generate
        if (ADR_IN_W > ADR_OUT_W) begin : g_oor
            assign w_in_oor = |s_adr[ADR_IN_W-1:ADR_OUT_W];
        end else begin : g_no_oor
            assign w_in_oor = 1'b0;
        end
    endgenerate

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_stall = s_cyc & (w_full | r_drain);
    assign w_push  = s_cyc & s_stb & ~w_stall;
    assign w_abort = ~s_cyc & ~w_empty;

    // An empty FIFO presents the incoming request as head so issue starts the cycle after accept.
    assign w_hd_valid = ~w_empty | w_push;
    assign w_hd_adr   = w_empty ? s_adr[ADR_OUT_W-1:0] : r_fifo_adr[r_rd];
    assign w_hd_dat   = w_empty ? s_dat_w              : r_fifo_dat[r_rd];
    assign w_hd_sel   = w_empty ? s_sel                : r_fifo_sel[r_rd];
    assign w_hd_we    = w_empty ? s_we                 : r_fifo_we[r_rd];
    assign w_hd_oor   = w_empty ? w_in_oor             : r_fifo_oor[r_rd];

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_issue) begin
            r_to_cnt <= TW'(1);
        end else if (r_state == ST_ISSUE && r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_timeout = (r_state == ST_ISSUE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_resp = m_ack | m_err | w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_cyc_end   = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_load_dat  = 1'b0;
        w_flush     = 1'b0;
        w_keep      = 1'b0;
        w_drain_nxt = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (w_abort) begin
                    w_flush = 1'b1;
                end else if (w_hd_valid) begin
                    if (w_hd_oor) begin
                        w_pop     = 1'b1;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_resp) begin
                    w_cyc_end   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_drain_nxt = 1'b0;
                    if (!(r_drain || w_abort)) begin
                        if (m_err || (w_timeout && !m_ack)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_ack_nxt  = 1'b1;
                            w_load_dat = 1'b1;
                        end
                    end
                end
                // Abort keeps only the in-flight head, which still has to finish on the slave.
                if (w_abort) begin
                    w_flush = 1'b1;
                    if (!w_resp) begin
                        w_keep      = 1'b1;
                        w_drain_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_adr[r_wr] <= s_adr[ADR_OUT_W-1:0];
            r_fifo_dat[r_wr] <= s_dat_w;
            r_fifo_sel[r_wr] <= s_sel;
            r_fifo_we[r_wr]  <= s_we;
            r_fifo_oor[r_wr] <= w_in_oor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            if (w_flush) begin
                r_rd    <= r_rd + PW'(w_pop);
                r_wr    <= r_rd + PW'(w_pop) + PW'(w_keep);
                r_count <= CW'(w_keep);
            end else begin
                r_rd    <= r_rd + PW'(w_pop);
                r_wr    <= r_wr + PW'(w_push);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_ack   <= 1'b0;
            r_s_err   <= 1'b0;
            r_s_dat_r <= '0;
            r_m_cyc   <= 1'b0;
            r_m_adr   <= '0;
            r_m_dat_w <= '0;
            r_m_sel   <= '0;
            r_m_we    <= 1'b0;
        end else begin
            r_s_ack <= w_ack_nxt;
            r_s_err <= w_err_nxt;
            if (w_load_dat) begin
                r_s_dat_r <= m_dat_r;
            end
            if (w_issue) begin
                r_m_cyc   <= 1'b1;
                r_m_adr   <= w_hd_adr;
                r_m_dat_w <= w_hd_dat;
                r_m_sel   <= w_hd_sel;
                r_m_we    <= w_hd_we;
            end else if (w_cyc_end) begin
                r_m_cyc <= 1'b0;
            end
        end
    end

    assign s_stall     = w_stall;
    assign s_ack       = r_s_ack;
    assign s_err       = r_s_err;
    assign s_dat_r     = r_s_dat_r;
    assign m_cyc       = r_m_cyc;
    assign m_stb       = r_m_cyc;
    assign m_adr       = r_m_adr;
    assign m_dat_w     = r_m_dat_w;
    assign m_sel       = r_m_sel;
    assign m_we        = r_m_we;
    assign outstanding = r_count;

endmodule
